// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared constants for the 5-stage MIPS pipeline: the NOP encoding, the
// rs/rt field positions, the WB/M/EX control-field widths, and the IF/ID
// register update action.
// ---------------------------------------------------------------------------
package mips_pkg;

    // sll $0,$0,0 encodes as all zeros
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Register-number fields of an R/I-type instruction
    localparam int RS_HI = 25;
    localparam int RS_LO = 21;
    localparam int RT_HI = 20;
    localparam int RT_LO = 16;

    // Control-field widths carried through ID/EX
    localparam int WB_W = 2;
    localparam int M_W  = 2;
    localparam int EX_W = 3;

    // Position of MemRead inside the M control field
    localparam int M_MEMREAD_BIT = 1;

    // What the IF/ID register does on a given edge, in priority order
    typedef enum logic [1:0] {
        IFID_LOAD  = 2'd0,
        IFID_STALL = 2'd1,
        IFID_FLUSH = 2'd2
    } ifid_action_e;

endpackage

// File: rtl/hazard_detect_unit.sv
// ---------------------------------------------------------------------------
// hazard_detect_unit
// Combinational load-use detector. Flags a hazard when the instruction in
// ID/EX is a load whose destination (rt) is read by the instruction in IF/ID.
// rs and rt are compared for every opcode, so a false stall on an
// instruction that ignores rt is possible and harmless.
//
// Ports:
//   valid         in   1  IF/ID holds a real instruction
//   idex_memread  in   1  MemRead bit of the ID/EX M field
//   idex_rt       in   5  destination register of the load in ID/EX
//   ifid_rs       in   5  rs field of the instruction in IF/ID
//   ifid_rt       in   5  rt field of the instruction in IF/ID
//   hazard        out  1  stall IF/ID and PC, bubble ID/EX
// ---------------------------------------------------------------------------
module hazard_detect_unit (
    input  logic       valid,
    input  logic       idex_memread,
    input  logic [4:0] idex_rt,
    input  logic [4:0] ifid_rs,
    input  logic [4:0] ifid_rt,
    output logic       hazard
);

    // $zero is never a real dependency
    assign hazard = valid && idex_memread && (idex_rt != 5'd0) &&
                    ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));

endmodule

// File: rtl/if_id_hazard_stage.sv
// ---------------------------------------------------------------------------
// if_id_hazard_stage
// IF/ID pipeline register with load-use stall and branch flush. Produces the
// PC write enable and the control bubble for ID/EX, and keeps saturating
// stall/flush event counters for performance debug.
//
// Ports:
//   clk            in   1      pipeline clock, rising edge
//   rst            in   1      asynchronous active-high reset
//   pc_plus4_in    in   32     PC+4 from IF
//   instr_in       in   32     fetched instruction from IF
//   branch_taken   in   1      resolved taken branch/jump; flush IF/ID
//   idex_memread   in   1      MemRead of the instruction in ID/EX
//   idex_rt        in   5      rt of the instruction in ID/EX
//   pc_plus4_out   out  32     registered PC+4 to ID
//   instr_out      out  32     registered instruction to ID
//   valid_out      out  1      instr_out is a real instruction
//   pc_write       out  1      PC update enable
//   ctrl_bubble    out  1      zero the WB/M/EX control entering ID/EX
//   stall_count    out  CNT_W  saturating load-use stall cycles
//   flush_count    out  CNT_W  saturating flush cycles
// ---------------------------------------------------------------------------
module if_id_hazard_stage
    import mips_pkg::*;
#(
    parameter int          CNT_W     = 16,
    parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      pc_plus4_in,
    input  logic [31:0]      instr_in,
    input  logic             branch_taken,
    input  logic             idex_memread,
    input  logic [4:0]       idex_rt,
    output logic [31:0]      pc_plus4_out,
    output logic [31:0]      instr_out,
    output logic             valid_out,
    output logic             pc_write,
    output logic             ctrl_bubble,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    logic         hazard;
    ifid_action_e action;

    hazard_detect_unit u_hazard (
        .valid        (valid_out),
        .idex_memread (idex_memread),
        .idex_rt      (idex_rt),
        .ifid_rs      (instr_out[RS_HI:RS_LO]),
        .ifid_rt      (instr_out[RT_HI:RT_LO]),
        .hazard       (hazard)
    );

    // Flush outranks a stall: the held instruction is on the wrong path anyway
    always_comb begin
        // NOTE: default first so every path assigns action and no latch is inferred
        action = IFID_LOAD;
        if (branch_taken)
            action = IFID_FLUSH;
        else if (hazard)
            action = IFID_STALL;
    end

    assign pc_write    = ~hazard | branch_taken;
    assign ctrl_bubble = hazard | ~valid_out;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_plus4_out <= 32'd0;
            instr_out    <= NOP_INSTR;
            valid_out    <= 1'b0;
            stall_count  <= '0;
            flush_count  <= '0;
        end else begin
            unique case (action)
                IFID_FLUSH: begin
                    pc_plus4_out <= 32'd0;
                    instr_out    <= NOP_INSTR;
                    valid_out    <= 1'b0;
                    if (flush_count != '1)
                        flush_count <= flush_count + 1'b1;
                end
                IFID_STALL: begin
                    if (stall_count != '1)
                        stall_count <= stall_count + 1'b1;
                end
                default: begin
                    pc_plus4_out <= pc_plus4_in;
                    instr_out    <= instr_in;
                    valid_out    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_id_hazard_stage.sv
module tb_if_id_hazard_stage;

    // Narrow counters so saturation is reachable with a short directed run
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             clk = 1'b0;
    logic             rst;
    logic [31:0]      pc_plus4_in;
    logic [31:0]      instr_in;
    logic             branch_taken;
    logic             idex_memread;
    logic [4:0]       idex_rt;
    logic [31:0]      pc_plus4_out;
    logic [31:0]      instr_out;
    logic             valid_out;
    logic             pc_write;
    logic             ctrl_bubble;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    int errors = 0;
    int checks = 0;

    if_id_hazard_stage #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_plus4_in  (pc_plus4_in),
        .instr_in     (instr_in),
        .branch_taken (branch_taken),
        .idex_memread (idex_memread),
        .idex_rt      (idex_rt),
        .pc_plus4_out (pc_plus4_out),
        .instr_out    (instr_out),
        .valid_out    (valid_out),
        .pc_write     (pc_write),
        .ctrl_bubble  (ctrl_bubble),
        .stall_count  (stall_count),
        .flush_count  (flush_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                                 input logic v, input logic pw, input logic bub,
                                 input int sc, input int fc);
        check({tag, ".pc"},     pc_plus4_out, pc);
        check({tag, ".instr"},  instr_out, ins);
        check({tag, ".valid"},  {31'd0, valid_out}, {31'd0, v});
        check({tag, ".pcw"},    {31'd0, pc_write}, {31'd0, pw});
        check({tag, ".bubble"}, {31'd0, ctrl_bubble}, {31'd0, bub});
        check({tag, ".stall"},  {28'd0, stall_count}, sc);
        check({tag, ".flush"},  {28'd0, flush_count}, fc);
    endtask

    initial begin
        rst = 1'b1;
        pc_plus4_in = 32'd0;
        instr_in = 32'd0;
        branch_taken = 1'b0;
        idex_memread = 1'b0;
        idex_rt = 5'd0;
        step();
        step();
        check_outputs("reset", 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, 0, 0);

        // Streaming adds: outputs follow one edge later
        rst = 1'b0;
        pc_plus4_in = 32'h4;
        instr_in = 32'h012A_4020;
        step();
        check_outputs("load1", 32'h4, 32'h012A_4020, 1'b1, 1'b1, 1'b0, 0, 0);
        pc_plus4_in = 32'h8;
        instr_in = 32'h0109_5020;
        step();
        check_outputs("load2", 32'h8, 32'h0109_5020, 1'b1, 1'b1, 1'b0, 0, 0);

        // Load-use on rs=8: one stall, then the held instruction advances
        idex_memread = 1'b1;
        idex_rt = 5'd8;
        pc_plus4_in = 32'hC;
        instr_in = 32'h0000_1020;
        #1;
        check_outputs("hz_comb", 32'h8, 32'h0109_5020, 1'b1, 1'b0, 1'b1, 0, 0);
        step();
        check_outputs("hz_hold", 32'h8, 32'h0109_5020, 1'b1, 1'b0, 1'b1, 1, 0);
        idex_memread = 1'b0;
        #1;
        check_outputs("hz_drop", 32'h8, 32'h0109_5020, 1'b1, 1'b1, 1'b0, 1, 0);
        step();
        check_outputs("hz_adv", 32'hC, 32'h0000_1020, 1'b1, 1'b1, 1'b0, 1, 0);

        // idex_rt=0 never stalls, even against rs=rt=0
        idex_memread = 1'b1;
        idex_rt = 5'd0;
        pc_plus4_in = 32'h10;
        instr_in = 32'h0085_1020;
        #1;
        check_outputs("rt0_comb", 32'hC, 32'h0000_1020, 1'b1, 1'b1, 1'b0, 1, 0);
        step();
        check_outputs("rt0_load", 32'h10, 32'h0085_1020, 1'b1, 1'b1, 1'b0, 1, 0);

        // Hazard through rt field (rt=5), then flush on the same cycle
        idex_rt = 5'd5;
        #1;
        check_outputs("rt_hz", 32'h10, 32'h0085_1020, 1'b1, 1'b0, 1'b1, 1, 0);
        branch_taken = 1'b1;
        #1;
        check({"flush_comb", ".pcw"}, {31'd0, pc_write}, 32'd1);
        step();
        check_outputs("flush", 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, 1, 1);

        // Load a lw $9,0($8) and hold a hazard on rs=8 until stall_count saturates
        branch_taken = 1'b0;
        idex_memread = 1'b0;
        pc_plus4_in = 32'h14;
        instr_in = 32'h8D09_0000;
        step();
        check_outputs("lw_load", 32'h14, 32'h8D09_0000, 1'b1, 1'b1, 1'b0, 1, 1);
        idex_memread = 1'b1;
        idex_rt = 5'd8;
        pc_plus4_in = 32'h18;
        instr_in = 32'h0000_0020;
        for (int i = 0; i < 20; i++) step();
        check_outputs("stall_sat", 32'h14, 32'h8D09_0000, 1'b1, 1'b0, 1'b1, CNT_MAX, 1);

        // Hold branch_taken until flush_count saturates
        branch_taken = 1'b1;
        for (int i = 0; i < 20; i++) step();
        check_outputs("flush_sat", 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, CNT_MAX, CNT_MAX);

        // Back to a normal load, then assert reset between edges
        branch_taken = 1'b0;
        idex_memread = 1'b0;
        step();
        check_outputs("pre_rst", 32'h18, 32'h0000_0020, 1'b1, 1'b1, 1'b0, CNT_MAX, CNT_MAX);
        #2;
        rst = 1'b1;
        #1;
        check_outputs("async_rst", 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, 0, 0);

        // Reset held across an edge with flush requested, then a clean load
        branch_taken = 1'b1;
        step();
        branch_taken = 1'b0;
        rst = 1'b0;
        pc_plus4_in = 32'h40;
        instr_in = 32'h012A_4020;
        step();
        check_outputs("post_rst", 32'h40, 32'h012A_4020, 1'b1, 1'b1, 1'b0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
